ahbl_gpio_port: RTL and testbench

AHBL_GPIO_PORT -- requirements
Module: ahbl_gpio_port

---
 rtl/ahbl_gpio_port_if.sv | 32 +++
 rtl/ahbl_gpio_port.sv | 171 +++++++++++++++++
 tb/tb_ahbl_gpio_port.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ahbl_gpio_port_if.sv
// ---------------------------------------------------------------------------
// ahbl_gpio_port_if
// AHB-Lite bus bundle for the GPIO port. The master modport is used by
// whatever drives the bus (the decoder/master side). The slave modport is
// used by the GPIO block.
//
// Signals:
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA : master -> slave
//   HRDATA, HREADYOUT, HRESP                           : slave -> master
// ---------------------------------------------------------------------------
interface ahbl_gpio_port_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahbl_gpio_port.sv
// ---------------------------------------------------------------------------
// ahbl_gpio_port
// 32-bit AHB-Lite GPIO port with zero wait states. The pad inputs pass
// through a two-flop synchronizer. A third flop provides per-bit
// rising/falling edge detection. Edge events latch into a W1C raw
// interrupt status register. A mask register then gates those status bits
// onto a level interrupt.
//
// Ports:
//   HCLK      : clock, rising edge
//   HRESETn   : asynchronous active-low reset
//   ahb       : AHB-Lite slave bus (ahbl_gpio_port_if.slave)
//   GPIO_IN   : asynchronous pad inputs
//   GPIO_OUT  : pad output values (DATA_OUT register)
//   GPIO_OE   : pad output enables (OE register)
//   IRQ       : level interrupt, |(RIS & IM)
//
// Register map (HADDR[4:2]):
//   0 DATA_IN (RO)
//   1 DATA_OUT
//   2 OE
//   3 EDGE (1 = rising)
//   4 IM
//   5 RIS (W1C)
//   6 MIS (RO)
//   7 reserved
// ---------------------------------------------------------------------------
module ahbl_gpio_port (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahbl_gpio_port_if.slave       ahb,
   input  logic [31:0]           GPIO_IN,
   output logic [31:0]           GPIO_OUT,
   output logic [31:0]           GPIO_OE,
   output logic                  IRQ
);

   localparam logic [2:0] ADDR_DIN  = 3'd0;
   localparam logic [2:0] ADDR_DOUT = 3'd1;
   localparam logic [2:0] ADDR_OE   = 3'd2;
   localparam logic [2:0] ADDR_EDGE = 3'd3;
   localparam logic [2:0] ADDR_IM   = 3'd4;
   localparam logic [2:0] ADDR_RIS  = 3'd5;
   localparam logic [2:0] ADDR_MIS  = 3'd6;
   localparam logic [2:0] SIZE_WORD = 3'b010;

   logic [31:0] dataOut_q, dataOut_d;
   logic [31:0] oe_q,      oe_d;
   logic [31:0] edgeSel_q, edgeSel_d;
   logic [31:0] im_q,      im_d;
   logic [31:0] ris_q,     ris_d;
   logic [31:0] s1_q, s2_q, s3_q;

   logic        dpValid_q, dpValid_d;
   logic [2:0]  dpAddr_q,  dpAddr_d;
   logic        dpWrite_q, dpWrite_d;
   logic [2:0]  dpSize_q,  dpSize_d;

   logic        accept;
   logic        wrCommit;
   logic [31:0] risClr;
   logic [31:0] rise, fall, ev;
   logic [31:0] rdata;
   logic        unusedBits;

   // Only HADDR[4:2] and HTRANS[1] carry meaning for this slave.
   assign unusedBits = ^{ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HTRANS[0]};

   assign accept   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
   // Sub-word writes are dropped entirely rather than partially merged.
   assign wrCommit = dpValid_q & dpWrite_q & (dpSize_q == SIZE_WORD);

   // Edge events come from the synchronized s2/s3 pair. Changing EDGE alone
   // therefore never fires an event.
   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;
   assign ev   = (edgeSel_q & rise) | (~edgeSel_q & fall);

   // Data-phase bookkeeping. The valid flag simply follows acceptance, so it
   // drops on any edge without a new transfer.
   always_comb begin
      dpValid_d = accept;
      dpAddr_d  = dpAddr_q;
      dpWrite_d = dpWrite_q;
      dpSize_d  = dpSize_q;
      if (accept) begin
         dpAddr_d  = ahb.HADDR[4:2];
         dpWrite_d = ahb.HWRITE;
         dpSize_d  = ahb.HSIZE;
      end
   end

   // Register write decode, committed on the edge that ends the data phase.
   // A RIS event arriving together with its clear keeps the bit set.
   always_comb begin
      dataOut_d = dataOut_q;
      oe_d      = oe_q;
      edgeSel_d = edgeSel_q;
      im_d      = im_q;
      risClr    = '0;
      if (wrCommit) begin
         case (dpAddr_q)
            ADDR_DOUT: dataOut_d = ahb.HWDATA;
            ADDR_OE:   oe_d      = ahb.HWDATA;
            ADDR_EDGE: edgeSel_d = ahb.HWDATA;
            ADDR_IM:   im_d      = ahb.HWDATA;
            ADDR_RIS:  risClr    = ahb.HWDATA;
            default:   ;
         endcase
      end
      ris_d = (ris_q & ~risClr) | ev;
   end

   // All state, including the input synchronizer chain.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dataOut_q <= '0;
         oe_q      <= '0;
         edgeSel_q <= '0;
         im_q      <= '0;
         ris_q     <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         dpValid_q <= 1'b0;
         dpAddr_q  <= '0;
         dpWrite_q <= 1'b0;
         dpSize_q  <= '0;
      end else begin
         dataOut_q <= dataOut_d;
         oe_q      <= oe_d;
         edgeSel_q <= edgeSel_d;
         im_q      <= im_d;
         ris_q     <= ris_d;
         s1_q      <= GPIO_IN;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         dpValid_q <= dpValid_d;
         dpAddr_q  <= dpAddr_d;
         dpWrite_q <= dpWrite_d;
         dpSize_q  <= dpSize_d;
      end
   end

   // Read mux. It is driven only while a read is in its data phase, so a
   // write committing on the same edge is already visible.
   always_comb begin
      rdata = '0;
      if (dpValid_q && !dpWrite_q) begin
         case (dpAddr_q)
            ADDR_DIN:  rdata = s2_q;
            ADDR_DOUT: rdata = dataOut_q;
            ADDR_OE:   rdata = oe_q;
            ADDR_EDGE: rdata = edgeSel_q;
            ADDR_IM:   rdata = im_q;
            ADDR_RIS:  rdata = ris_q;
            ADDR_MIS:  rdata = ris_q & im_q;
            default:   rdata = '0;
         endcase
      end
   end

   assign ahb.HRDATA    = rdata;
   assign ahb.HREADYOUT = 1'b1;
   assign ahb.HRESP     = 1'b0;

   assign GPIO_OUT = dataOut_q;
   assign GPIO_OE  = oe_q;
   assign IRQ      = |(ris_q & im_q);

endmodule

// File: tb/tb_ahbl_gpio_port.sv
// ---------------------------------------------------------------------------
// tb_ahbl_gpio_port
// Directed bench for ahbl_gpio_port. Inputs change on the falling edge and
// outputs are sampled there, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_ahbl_gpio_port;

   logic        HCLK;
   logic        HRESETn;
   logic [31:0] GPIO_IN;
   logic [31:0] GPIO_OUT;
   logic [31:0] GPIO_OE;
   logic        IRQ;

   int vectors    = 0;
   int miscompares = 0;

   ahbl_gpio_port_if bus ();

   ahbl_gpio_port dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .ahb      (bus),
      .GPIO_IN  (GPIO_IN),
      .GPIO_OUT (GPIO_OUT),
      .GPIO_OE  (GPIO_OE),
      .IRQ      (IRQ)
   );

   // Free-running 10-unit clock.
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // Advance to the next falling edge and drive one bus cycle.
   task automatic applyStimulus(input logic sel, input logic [31:0] addr,
                                input logic wr, input logic [2:0] size,
                                input logic [31:0] wdata);
      @(negedge HCLK);
      bus.HSEL   = sel;
      bus.HTRANS = sel ? 2'b10 : 2'b00;
      bus.HADDR  = addr;
      bus.HWRITE = wr;
      bus.HSIZE  = size;
      bus.HWDATA = wdata;
   endtask

   // One comparison, counted and reported on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Full write. The task returns on the falling edge after the commit edge.
   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] size);
      applyStimulus(1'b1, addr, 1'b1, size, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, data);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
   endtask

   // Full read. HRDATA is checked mid data phase.
   task automatic busRead(input logic [31:0] addr, input logic [31:0] expected,
                          input string tag);
      applyStimulus(1'b1, addr, 1'b0, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput(tag, bus.HRDATA, expected);
   endtask

   // Directed sequence.
   initial begin
      HRESETn    = 1'b0;
      GPIO_IN    = 32'h0;
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HADDR  = 32'h0;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = 3'b010;
      bus.HREADY = 1'b1;
      bus.HWDATA = 32'h0;

      // Reset state
      repeat (2) @(negedge HCLK);
      checkOutput("rst_gpio_out", GPIO_OUT, 32'h0);
      checkOutput("rst_gpio_oe", GPIO_OE, 32'h0);
      checkOutput("rst_irq", 32'(IRQ), 32'h0);
      checkOutput("rst_hrdata", bus.HRDATA, 32'h0);
      checkOutput("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
      checkOutput("rst_hresp", 32'(bus.HRESP), 32'h0);
      HRESETn = 1'b1;

      // OE write. The pads change one cycle after the address phase.
      applyStimulus(1'b1, 32'h08, 1'b1, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'hA5A5_0000);
      checkOutput("oe_before_commit", GPIO_OE, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("oe_after_commit", GPIO_OE, 32'hA5A5_0000);
      busWrite(32'h04, 32'h1234_5678, 3'b010);
      checkOutput("gpio_out", GPIO_OUT, 32'h1234_5678);
      busRead(32'h08, 32'hA5A5_0000, "rd_oe");
      busRead(32'h04, 32'h1234_5678, "rd_data_out");

      // Synchronizer latency while streaming DATA_IN reads
      applyStimulus(1'b1, 32'h00, 1'b0, 3'b010, 32'h0);
      GPIO_IN = 32'h0000_0064;
      applyStimulus(1'b1, 32'h00, 1'b0, 3'b010, 32'h0);
      checkOutput("din_after_1_edge", bus.HRDATA, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("din_after_2_edges", bus.HRDATA, 32'h0000_0064);

      // Rising edge on bit 0 with EDGE[0]=1 and IM=1
      busWrite(32'h0C, 32'h1, 3'b010);
      busWrite(32'h10, 32'h1, 3'b010);
      GPIO_IN = 32'h0000_0065;
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("irq_after_2_edges", 32'(IRQ), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("irq_after_3_edges", 32'(IRQ), 32'h1);
      busRead(32'h14, 32'h1, "rd_ris_set");
      busRead(32'h18, 32'h1, "rd_mis_set");
      busWrite(32'h14, 32'h1, 3'b010);
      checkOutput("irq_after_w1c", 32'(IRQ), 32'h0);

      // A falling edge on bit 0 is not an event while EDGE[0]=1
      GPIO_IN = 32'h0000_0064;
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("irq_after_fall", 32'(IRQ), 32'h0);
      busRead(32'h14, 32'h0, "rd_ris_after_fall");

      // The event wins over a W1C committing on the same edge
      GPIO_IN = 32'h0000_0065;
      applyStimulus(1'b1, 32'h14, 1'b1, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("irq_event_vs_clear", 32'(IRQ), 32'h1);
      busRead(32'h14, 32'h1, "rd_ris_event_vs_clear");
      busWrite(32'h14, 32'h1, 3'b010);
      checkOutput("irq_cleared_again", 32'(IRQ), 32'h0);

      // Back-to-back: write IM, then read IM with no gap
      applyStimulus(1'b1, 32'h10, 1'b1, 3'b010, 32'h0);
      applyStimulus(1'b1, 32'h10, 1'b0, 3'b010, 32'hFFFF_FFFF);
      checkOutput("b2b_hreadyout_a", 32'(bus.HREADYOUT), 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("b2b_read_im", bus.HRDATA, 32'hFFFF_FFFF);
      checkOutput("b2b_hreadyout_b", 32'(bus.HREADYOUT), 32'h1);

      // A byte write is ignored. The reserved slot reads zero.
      busWrite(32'h04, 32'h0000_00FF, 3'b000);
      checkOutput("byte_wr_gpio_out", GPIO_OUT, 32'h1234_5678);
      busRead(32'h04, 32'h1234_5678, "rd_after_byte_wr");
      busRead(32'h1C, 32'h0, "rd_reserved");

      // A falling edge on bit 2 (EDGE[2]=0) sets RIS[2] and raises IRQ.
      GPIO_IN = 32'h0000_0061;
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      checkOutput("irq_fall_bit2", 32'(IRQ), 32'h1);
      busRead(32'h18, 32'h0000_0004, "rd_mis_bit2");

      // Reset pulsed during the data phase of a DATA_OUT write
      applyStimulus(1'b1, 32'h04, 1'b1, 3'b010, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'hDEAD_BEEF);
      HRESETn = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 3'b010, 32'h0);
      HRESETn = 1'b1;
      checkOutput("mid_rst_gpio_out", GPIO_OUT, 32'h0);
      checkOutput("mid_rst_gpio_oe", GPIO_OE, 32'h0);
      checkOutput("mid_rst_irq", 32'(IRQ), 32'h0);
      busRead(32'h04, 32'h0, "mid_rst_rd_data_out");
      busRead(32'h08, 32'h0, "mid_rst_rd_oe");
      busRead(32'h0C, 32'h0, "mid_rst_rd_edge");
      busRead(32'h10, 32'h0, "mid_rst_rd_im");
      busRead(32'h14, 32'h0, "mid_rst_rd_ris");
      busRead(32'h18, 32'h0, "mid_rst_rd_mis");
      busRead(32'h00, 32'h0000_0061, "post_rst_rd_data_in");
      checkOutput("post_rst_irq", 32'(IRQ), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
